// File: rtl/bcd_count_ctrl_if.sv
// Control/status bundle for bcd_count_ctrl: one-cycle command pulses in,
// BCD count and step pulses out. The DUT side uses modport slave.
interface bcd_count_ctrl_if #(
  parameter int DIGITS = 4
);
  // No valid/ready pairs here: start/pause/clear/load are single-cycle pulses
  // sampled on every rising clk edge (always accepted); tick/wrap are
  // single-cycle status pulses the consumer must sample in that cycle.
  logic                start;
  logic                pause;
  logic                clear;
  logic                load;
  logic [4*DIGITS-1:0] load_val;
  logic                up;
  logic [4*DIGITS-1:0] q;
  logic                tick;
  logic                wrap;
  logic                running;
  logic [1:0]          state_dbg;

  modport master (
    output start, pause, clear, load, load_val, up,
    input  q, tick, wrap, running, state_dbg
  );

  modport slave (
    input  start, pause, clear, load, load_val, up,
    output q, tick, wrap, running, state_dbg
  );
endinterface

// File: rtl/bcd_count_ctrl.sv
// Multi-digit BCD counter stepped by a prescaler under an IDLE/RUN/PAUSE FSM.
// Define BCD_COUNT_DOWN_EN to enable down counting via bus.up.
module bcd_count_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  bcd_count_ctrl_if.slave  bus
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [W-1:0]  q_r;
  logic          tick_r;
  logic          wrap_r;
  logic [W:0]    next_cnt;  // {wrap, next value}
  logic          resume;

  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (d == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

`ifdef BCD_COUNT_DOWN_EN
  function automatic logic [W:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    logic [3:0]   d;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (b) begin
        if (d == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          b = 1'b0;
        end
      end
    end
    return {b, r};
  endfunction
`endif

  // Non-BCD nibbles in a load are forced to zero so q never shows a digit > 9.
  function automatic logic [W-1:0] bcd_coerce(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
    end
    return r;
  endfunction

`ifdef BCD_COUNT_DOWN_EN
  assign next_cnt = bus.up ? bcd_inc(q_r) : bcd_dec(q_r);
`else
  assign next_cnt = bcd_inc(q_r);
`endif

  // Pause beats start when both arrive in the same cycle.
  assign resume = bus.start && !bus.pause;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      presc  <= '0;
      q_r    <= '0;
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      wrap_r <= 1'b0;
      if (bus.clear) begin
        state <= IDLE;
        q_r   <= '0;
        presc <= '0;
      end else if (bus.load) begin
        q_r   <= bcd_coerce(bus.load_val);
        presc <= '0;
      end else begin
        case (state)
          IDLE: begin
            presc <= '0;
            if (resume) state <= RUN;
          end
          RUN: begin
            // A pause on what would be the step edge swallows the step.
            if (bus.pause) begin
              state <= PAUSE;
            end else if (presc == PMAX) begin
              presc  <= '0;
              q_r    <= next_cnt[W-1:0];
              tick_r <= 1'b1;
              wrap_r <= next_cnt[W];
            end else begin
              presc <= presc + 1'b1;
            end
          end
          PAUSE: begin
            if (resume) state <= RUN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.q         = q_r;
  assign bus.tick      = tick_r;
  assign bus.wrap      = wrap_r;
  assign bus.running   = (state == RUN);
  assign bus.state_dbg = state;
endmodule
